// File: rtl/touch_key_if.sv
// Command/status bundle between a touch-key burst requester and the generator.
// The generator uses the slave side: it receives commands and drives key level and status.
interface touch_key_if;
  logic       start;
  logic [3:0] press_num;
  logic       long_en;
  logic       abort;
  logic       touch_key;
  logic       busy;
  logic       done;
  logic [3:0] press_cnt;

  modport master (
    output start, press_num, long_en, abort,
    input  touch_key, busy, done, press_cnt
  );

  modport slave (
    input  start, press_num, long_en, abort,
    output touch_key, busy, done, press_cnt
  );
endinterface

// File: rtl/touch_key_gen.sv
// Touch-key stimulus transmitter: emits a burst of timed high presses, each followed
// by a low gap, then a one-cycle done pulse. All outputs come straight from flops.
module touch_key_gen #(
  parameter int CNT_W        = 25,
  parameter int PRESS_CYCLES = 5_000_000,
  parameter int LONG_CYCLES  = 25_000_000,
  parameter int GAP_CYCLES   = 5_000_000
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  touch_key_if.slave   kif
);

  localparam int MAX_CYCLES = (PRESS_CYCLES > LONG_CYCLES) ?
                              ((PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES) :
                              ((LONG_CYCLES  > GAP_CYCLES) ? LONG_CYCLES  : GAP_CYCLES);

  if (PRESS_CYCLES < 1 || LONG_CYCLES < 1 || GAP_CYCLES < 1 ||
      longint'(MAX_CYCLES - 1) >= (longint'(1) << CNT_W)) begin : g_bad_params
    $error("touch_key_gen: cycle counts must be >=1 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] PRESS_M1 = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_M1  = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_M1   = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_GAP,
    ST_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       num_q, num_d;
  logic             long_q, long_d;
  logic [3:0]       press_cnt_q, press_cnt_d;
  logic             touch_key_q, touch_key_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] hold_m1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    num_d       = num_q;
    long_d      = long_q;
    press_cnt_d = press_cnt_q;
    hold_m1     = long_q ? LONG_M1 : PRESS_M1;

    case (state_q)
      // FIN is not busy, so a start there is accepted exactly as from IDLE.
      ST_IDLE, ST_FIN: begin
        state_d = ST_IDLE;
        if (kif.start) begin
          num_d       = kif.press_num;
          long_d      = kif.long_en;
          press_cnt_d = 4'd0;
          cnt_d       = '0;
          state_d     = (kif.press_num != 4'd0) ? ST_PRESS : ST_FIN;
        end
      end
      ST_PRESS: begin
        if (cnt_q == hold_m1) begin
          cnt_d       = '0;
          press_cnt_d = press_cnt_q + 4'd1;
          state_d     = ST_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_M1) begin
          cnt_d   = '0;
          state_d = (press_cnt_q < num_q) ? ST_PRESS : ST_FIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over start and timers; the completed-press count is kept for inspection.
    if (kif.abort && state_q != ST_IDLE) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      num_d       = num_q;
      long_d      = long_q;
      press_cnt_d = press_cnt_q;
    end

    touch_key_d = (state_d == ST_PRESS);
    busy_d      = (state_d == ST_PRESS) || (state_d == ST_GAP);
    done_d      = (state_d == ST_FIN);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      num_q       <= 4'd0;
      long_q      <= 1'b0;
      press_cnt_q <= 4'd0;
      touch_key_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      long_q      <= long_d;
      press_cnt_q <= press_cnt_d;
      touch_key_q <= touch_key_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign kif.touch_key = touch_key_q;
  assign kif.busy      = busy_q;
  assign kif.done      = done_q;
  assign kif.press_cnt = press_cnt_q;

endmodule

// File: tb/tb_touch_key_gen.sv
// Randomized scoreboard bench for touch_key_gen: bursts are predicted from the timing
// rules with plain arithmetic and checked by an independent monitor on each done pulse.
module tb_touch_key_gen;

  localparam int PRESS = 4;
  localparam int LONG  = 10;
  localparam int GAP   = 3;

  typedef struct {
    int done_cyc;
    int pcnt;
    int hold;
    int busy_len;
    int first_rise;
  } exp_t;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  int   cyc       = 0;
  int   total     = 0;
  int   bad       = 0;
  exp_t sb[$];

  touch_key_if kif();

  touch_key_gen #(
    .CNT_W        (25),
    .PRESS_CYCLES (PRESS),
    .LONG_CYCLES  (LONG),
    .GAP_CYCLES   (GAP)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .kif       (kif)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue a start at the current negedge; returns on the next negedge with start dropped.
  task automatic apply_stimulus(input int n, input bit l, input bit push, output int done_cyc);
    int hold;
    exp_t e;
    hold          = l ? LONG : PRESS;
    kif.start     = 1'b1;
    kif.press_num = 4'(n);
    kif.long_en   = l;
    done_cyc      = cyc + 1 + n * (hold + GAP);
    e.done_cyc    = done_cyc;
    e.pcnt        = n;
    e.hold        = hold;
    e.busy_len    = n * (hold + GAP);
    e.first_rise  = cyc + 1;
    if (push) sb.push_back(e);
    @(negedge sys_clk);
    kif.start = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge sys_clk);
  endtask

  // Monitor: measures each burst's key waveform and checks it when done appears.
  int rises = 0, run = 0, min_run = 1000, max_run = 0, busy_cnt = 0, first_rise = -1;

  always @(negedge sys_clk) begin
    exp_t e;
    if (!sys_rst_n) begin
      rises = 0; run = 0; min_run = 1000; max_run = 0; busy_cnt = 0; first_rise = -1;
    end else begin
      if (kif.touch_key) begin
        if (run == 0) begin
          rises++;
          if (rises == 1) first_rise = cyc;
        end
        run++;
      end else if (run > 0) begin
        if (run < min_run) min_run = run;
        if (run > max_run) max_run = run;
        run = 0;
      end
      if (kif.busy) busy_cnt++;
      if (kif.touch_key && !kif.busy) check_output("key_without_busy", 1, 0);
      if (kif.done) begin
        if (sb.size() == 0) begin
          check_output("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check_output("done_cycle", cyc, e.done_cyc);
          check_output("press_cnt_at_done", int'(kif.press_cnt), e.pcnt);
          check_output("press_count", rises, e.pcnt);
          check_output("busy_cycles", busy_cnt, e.busy_len);
          check_output("busy_at_done", int'(kif.busy), 0);
          if (e.pcnt > 0) begin
            check_output("first_rise", first_rise, e.first_rise);
            check_output("min_hold", min_run, e.hold);
            check_output("max_hold", max_run, e.hold);
          end
        end
        rises = 0; run = 0; min_run = 1000; max_run = 0; busy_cnt = 0; first_rise = -1;
      end else if (!kif.busy && !kif.touch_key) begin
        rises = 0; run = 0; min_run = 1000; max_run = 0; busy_cnt = 0; first_rise = -1;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k, dc, n, c;
    bit l;
    kif.start = 1'b0; kif.press_num = 4'd0; kif.long_en = 1'b0; kif.abort = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_output("rst_touch_key", int'(kif.touch_key), 0);
    check_output("rst_busy", int'(kif.busy), 0);
    check_output("rst_done", int'(kif.done), 0);
    check_output("rst_press_cnt", int'(kif.press_cnt), 0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Single short press, then busy/key visible the cycle after start.
    apply_stimulus(1, 1'b0, 1'b1, dc);
    check_output("latency_key", int'(kif.touch_key), 1);
    check_output("latency_busy", int'(kif.busy), 1);
    wait_until(dc + 2);

    // Three long presses with an ignored start (press_num=7) mid-burst.
    apply_stimulus(3, 1'b1, 1'b1, dc);
    wait_until(cyc + 5);
    kif.start = 1'b1; kif.press_num = 4'd7; kif.long_en = 1'b0;
    @(negedge sys_clk);
    kif.start = 1'b0;
    wait_until(dc + 2);

    // Zero presses: done next cycle, no key activity.
    apply_stimulus(0, 1'b0, 1'b1, dc);
    check_output("zero_busy", int'(kif.busy), 0);
    wait_until(dc + 2);

    // Abort during the second of three presses.
    k = cyc;
    apply_stimulus(3, 1'b0, 1'b0, dc);
    wait_until(k + 9);
    kif.abort = 1'b1;
    @(negedge sys_clk);
    kif.abort = 1'b0;
    check_output("abort_key", int'(kif.touch_key), 0);
    check_output("abort_busy", int'(kif.busy), 0);
    check_output("abort_done", int'(kif.done), 0);
    check_output("abort_press_cnt", int'(kif.press_cnt), 1);
    repeat (20) @(negedge sys_clk);

    // One-cycle reset in the middle of a press.
    k = cyc;
    apply_stimulus(2, 1'b0, 1'b0, dc);
    wait_until(k + 2);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    check_output("midrst_key", int'(kif.touch_key), 0);
    check_output("midrst_busy", int'(kif.busy), 0);
    check_output("midrst_done", int'(kif.done), 0);
    check_output("midrst_press_cnt", int'(kif.press_cnt), 0);
    repeat (10) @(negedge sys_clk);
    apply_stimulus(2, 1'b0, 1'b1, dc);
    wait_until(dc + 1);

    // Random bursts, sometimes restarted in the done cycle, with ignored mid-burst starts.
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 4);
      l = 1'($urandom_range(0, 1));
      k = cyc;
      apply_stimulus(n, l, 1'b1, dc);
      if ((dc - k - 1) >= 2 && $urandom_range(0, 1) == 1) begin
        c = k + 1 + $urandom_range(0, dc - k - 3);
        wait_until(c);
        kif.start = 1'b1;
        kif.press_num = 4'($urandom_range(0, 15));
        kif.long_en = 1'($urandom_range(0, 1));
        @(negedge sys_clk);
        kif.start = 1'b0;
      end
      kif.press_num = 4'($urandom_range(0, 15));
      wait_until(dc);
      if ($urandom_range(0, 3) != 0) repeat ($urandom_range(1, 3)) @(negedge sys_clk);
    end

    repeat (20) @(negedge sys_clk);
    check_output("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
